// File: rtl/ysyx_23060096_pkg.sv
// Shared encodings for the NPC memory arbiter: FSM states, transaction owner,
// and a helper that turns a one-hot grant into an owner.
package ysyx_23060096_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

  // Grant bit 0 is the IFU, bit 1 the LSU.
  function automatic owner_e grant_owner(input logic [1:0] grant);
    return grant[1] ? OWN_LSU : OWN_IFU;
  endfunction

endpackage

// File: rtl/ysyx_23060096_rr_arb2.sv
// Two-way round-robin arbiter: on a conflict the requester that did not win
// last time gets the grant. Bit 0 = IFU, bit 1 = LSU; grant is one-hot or zero.
module ysyx_23060096_rr_arb2
  import ysyx_23060096_pkg::*;
(
  input  logic [1:0] i_req,
  input  owner_e     i_last_grant,
  output logic [1:0] o_grant
);

  always_comb begin
    // NOTE: default assignment first so no path through this block infers a latch.
    o_grant = 2'b00;
    case (i_req)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = (i_last_grant == OWN_LSU) ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/ysyx_23060096_mem_arbiter.sv
// Shares the single NPC memory port between IFU and LSU, one transaction at a
// time, with a response watchdog that answers on memory's behalf if it stalls.
module ysyx_23060096_mem_arbiter
  import ysyx_23060096_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned RSP_TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_rsp_valid,
  input  logic                ifu_rsp_ready,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic                ifu_rsp_err,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_rsp_valid,
  input  logic                lsu_rsp_ready,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                lsu_rsp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_rsp_valid,
  output logic                mem_rsp_ready,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                timeout_err
);

  localparam int unsigned CNT_W = $clog2(RSP_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(RSP_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RSP_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e              r_state;
  owner_e              r_owner;
  owner_e              r_last_grant;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_timeout_err;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_wen;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W/8-1:0] r_wmask;

  logic [1:0]          w_grant;
  owner_e              w_win;
  logic                w_idle;
  logic                w_rsp;
  logic                w_accept;
  logic                w_wd_fire;
  logic                w_owner_rsp_ready;
  logic                w_rsp_valid;
  logic [DATA_W-1:0]   w_rdata;

  ysyx_23060096_rr_arb2 u_rr_arb2 (
    .i_req        ({lsu_req_valid, ifu_req_valid}),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant)
  );

  assign w_win    = grant_owner(w_grant);
  assign w_idle   = (r_state == ST_IDLE);
  assign w_rsp    = (r_state == ST_RSP);
  assign w_accept = w_idle && (w_grant != 2'b00);

  assign ifu_req_ready = w_idle && w_grant[0];
  assign lsu_req_ready = w_idle && w_grant[1];

  // Once the counter saturates the arbiter owns the response, not memory.
  assign w_wd_fire         = w_rsp && (r_cnt == CNT_MAX);
  assign w_owner_rsp_ready = (r_owner == OWN_LSU) ? lsu_rsp_ready : ifu_rsp_ready;
  assign w_rsp_valid       = w_rsp && (w_wd_fire || mem_rsp_valid);
  assign w_rdata           = w_wd_fire ? '0 : mem_rdata;

  assign ifu_rsp_valid = w_rsp_valid && (r_owner == OWN_IFU);
  assign lsu_rsp_valid = w_rsp_valid && (r_owner == OWN_LSU);
  assign ifu_rsp_err   = w_wd_fire && (r_owner == OWN_IFU);
  assign lsu_rsp_err   = w_wd_fire && (r_owner == OWN_LSU);
  assign ifu_rdata     = w_rdata;
  assign lsu_rdata     = w_rdata;
  assign mem_rsp_ready = w_rsp && !w_wd_fire && w_owner_rsp_ready;

  assign mem_req_valid = (r_state == ST_REQ);
  assign mem_addr      = r_addr;
  assign mem_wen       = r_wen;
  assign mem_wdata     = r_wdata;
  assign mem_wmask     = r_wmask;
  assign timeout_err   = r_timeout_err;

  always_ff @(posedge clk) begin
    // NOTE: every register here is state, so only non-blocking assignments;
    // the request field registers are reset too so mem_* reads 0 after reset.
    if (!rstn) begin
      r_state       <= ST_IDLE;
      r_owner       <= OWN_IFU;
      r_last_grant  <= OWN_LSU;
      r_cnt         <= '0;
      r_timeout_err <= 1'b0;
      r_addr        <= '0;
      r_wen         <= 1'b0;
      r_wdata       <= '0;
      r_wmask       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_owner      <= w_win;
            r_last_grant <= w_win;
            r_state      <= ST_REQ;
            if (w_win == OWN_LSU) begin
              r_addr  <= lsu_addr;
              r_wen   <= lsu_wen;
              r_wdata <= lsu_wdata;
              r_wmask <= lsu_wmask;
            end else begin
              r_addr  <= ifu_addr;
              r_wen   <= 1'b0;
              r_wdata <= '0;
              r_wmask <= '0;
            end
          end
        end
        ST_REQ: begin
          if (mem_req_ready) begin
            r_state <= ST_RSP;
            r_cnt   <= '0;
          end
        end
        ST_RSP: begin
          if (w_wd_fire || mem_rsp_valid) begin
            if (w_owner_rsp_ready) r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
            if (r_cnt == CNT_LAST) r_timeout_err <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060096_mem_arbiter.sv
// Directed bench for the IFU/LSU memory arbiter: a transaction-level model
// checked every cycle, plus literal expectations for each scenario.
module tb_ysyx_23060096_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = DW / 8;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic          ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready, ifu_rsp_err;
  logic [AW-1:0] ifu_addr;
  logic [DW-1:0] ifu_rdata;
  logic          lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid, lsu_rsp_ready, lsu_rsp_err;
  logic [AW-1:0] lsu_addr;
  logic [DW-1:0] lsu_wdata, lsu_rdata;
  logic [MW-1:0] lsu_wmask;
  logic          mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid, mem_rsp_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [MW-1:0] mem_wmask;
  logic          timeout_err;

  always #5 clk = ~clk;

  ysyx_23060096_mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .RSP_TIMEOUT(TO)
  ) u_dut (
    .clk(clk), .rstn(rstn),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rdata(ifu_rdata),
    .ifu_rsp_err(ifu_rsp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rdata(lsu_rdata),
    .lsu_rsp_err(lsu_rsp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rdata(mem_rdata),
    .timeout_err(timeout_err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int grants[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: an optional pending transaction that has or has
  // not been handed to memory, plus who is preferred on the next conflict.
  bit          m_init = 1'b0;
  bit          m_have, m_issued, m_owner_lsu, m_prefer_lsu, m_sticky, m_wen;
  int          m_silent;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [MW-1:0] m_wmask;

  function automatic bit exp_ifu_grant();
    return !m_have && ifu_req_valid && (!lsu_req_valid || !m_prefer_lsu);
  endfunction
  function automatic bit exp_lsu_grant();
    return !m_have && lsu_req_valid && (!ifu_req_valid || m_prefer_lsu);
  endfunction
  function automatic bit exp_err_mode();
    return m_have && m_issued && (m_silent >= TO);
  endfunction
  function automatic bit exp_owner_ready();
    return m_owner_lsu ? lsu_rsp_ready : ifu_rsp_ready;
  endfunction
  function automatic bit exp_rsp_valid();
    return exp_err_mode() || (m_have && m_issued && mem_rsp_valid);
  endfunction

  always @(posedge clk) begin
    if (!rstn) begin
      m_init <= 1'b1; m_have <= 1'b0; m_issued <= 1'b0; m_owner_lsu <= 1'b0;
      m_prefer_lsu <= 1'b0; m_silent <= 0; m_sticky <= 1'b0;
    end else if (m_init) begin
      if (!m_have) begin
        if (exp_ifu_grant()) begin
          m_have <= 1'b1; m_issued <= 1'b0; m_owner_lsu <= 1'b0; m_prefer_lsu <= 1'b1;
          m_addr <= ifu_addr; m_wen <= 1'b0; m_wdata <= '0; m_wmask <= '0;
        end else if (exp_lsu_grant()) begin
          m_have <= 1'b1; m_issued <= 1'b0; m_owner_lsu <= 1'b1; m_prefer_lsu <= 1'b0;
          m_addr <= lsu_addr; m_wen <= lsu_wen; m_wdata <= lsu_wdata; m_wmask <= lsu_wmask;
        end
      end else if (!m_issued) begin
        if (mem_req_ready) begin m_issued <= 1'b1; m_silent <= 0; end
      end else if (exp_err_mode() || mem_rsp_valid) begin
        if (exp_owner_ready()) m_have <= 1'b0;
      end else if (m_silent < TO) begin
        m_silent <= m_silent + 1;
        if (m_silent + 1 == TO) m_sticky <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      check("m_ifu_req_ready", 64'(ifu_req_ready), 64'(exp_ifu_grant()));
      check("m_lsu_req_ready", 64'(lsu_req_ready), 64'(exp_lsu_grant()));
      check("m_mem_req_valid", 64'(mem_req_valid), 64'(m_have && !m_issued));
      check("m_mem_rsp_ready", 64'(mem_rsp_ready),
            64'(m_have && m_issued && !exp_err_mode() && exp_owner_ready()));
      check("m_ifu_rsp_valid", 64'(ifu_rsp_valid), 64'(exp_rsp_valid() && !m_owner_lsu));
      check("m_lsu_rsp_valid", 64'(lsu_rsp_valid), 64'(exp_rsp_valid() && m_owner_lsu));
      check("m_ifu_rsp_err", 64'(ifu_rsp_valid && ifu_rsp_err), 64'(exp_err_mode() && !m_owner_lsu));
      check("m_lsu_rsp_err", 64'(lsu_rsp_valid && lsu_rsp_err), 64'(exp_err_mode() && m_owner_lsu));
      check("m_timeout_err", 64'(timeout_err), 64'(m_sticky));
      if (m_have && !m_issued) begin
        check("m_mem_addr", 64'(mem_addr), 64'(m_addr));
        check("m_mem_wen", 64'(mem_wen), 64'(m_wen));
        check("m_mem_wmask", 64'(mem_wmask), 64'(m_wmask));
        if (m_wen) check("m_mem_wdata", 64'(mem_wdata), 64'(m_wdata));
      end
      if (exp_rsp_valid() && (exp_err_mode() || !m_wen)) begin
        if (m_owner_lsu) check("m_lsu_rdata", 64'(lsu_rdata), exp_err_mode() ? 64'd0 : 64'(mem_rdata));
        else             check("m_ifu_rdata", 64'(ifu_rdata), exp_err_mode() ? 64'd0 : 64'(mem_rdata));
      end
      if (ifu_req_valid && ifu_req_ready) grants.push_back(0);
      if (lsu_req_valid && lsu_req_ready) grants.push_back(1);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    #2;
  endtask

  task automatic clr();
    ifu_req_valid = 0; ifu_addr = '0; ifu_rsp_ready = 0;
    lsu_req_valid = 0; lsu_addr = '0; lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0; lsu_rsp_ready = 0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int exp_g[3] = '{0, 1, 0};
    clr();
    rstn = 0;
    cyc(); cyc();
    rstn = 1;
    look();
    check("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
    check("rst_mem_rsp_ready", 64'(mem_rsp_ready), 64'd0);
    check("rst_rsp_valids", 64'({ifu_rsp_valid, lsu_rsp_valid}), 64'd0);
    check("rst_req_readys", 64'({ifu_req_ready, lsu_req_ready}), 64'd0);
    check("rst_timeout_err", 64'(timeout_err), 64'd0);
    check("rst_mem_fields", 64'({mem_wen, mem_wmask, mem_addr}), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);

    // IFU alone: accept, request, response in three cycles
    cyc(); ifu_req_valid = 1; ifu_addr = 32'h8000_0000; mem_req_ready = 1; ifu_rsp_ready = 1; look();
    check("t1_accept", 64'(ifu_req_ready), 64'd1);
    check("t1_no_req_yet", 64'(mem_req_valid), 64'd0);
    cyc(); ifu_req_valid = 0; look();
    check("t1_req_valid", 64'(mem_req_valid), 64'd1);
    check("t1_addr", 64'(mem_addr), 64'h8000_0000);
    check("t1_wen_wmask", 64'({mem_wen, mem_wmask}), 64'd0);
    cyc(); mem_req_ready = 0; mem_rsp_valid = 1; mem_rdata = 32'h0000_0413; look();
    check("t1_rsp_valid", 64'(ifu_rsp_valid), 64'd1);
    check("t1_rdata", 64'(ifu_rdata), 64'h0000_0413);
    check("t1_rsp_err", 64'(ifu_rsp_err), 64'd0);
    check("t1_mem_rsp_ready", 64'(mem_rsp_ready), 64'd1);
    cyc(); mem_rsp_valid = 0; look();
    check("t1_back_idle", 64'({mem_req_valid, ifu_rsp_valid}), 64'd0);

    // Simultaneous requests straight after reset, held valid: IFU, LSU, IFU
    cyc(); rstn = 0;
    cyc(); rstn = 1;
    ifu_req_valid = 1; ifu_addr = 32'h8000_0004;
    lsu_req_valid = 1; lsu_addr = 32'h8000_1000; lsu_wen = 0;
    mem_req_ready = 1; mem_rsp_valid = 1; mem_rdata = 32'hCAFE_0001;
    ifu_rsp_ready = 1; lsu_rsp_ready = 1;
    grants.delete();
    look();
    check("t2_ifu_first", 64'({ifu_req_ready, lsu_req_ready}), 64'b10);
    cyc(); look();
    check("t2_addr_ifu", 64'(mem_addr), 64'h8000_0004);
    cyc(); cyc(); look();
    check("t2_lsu_second", 64'({ifu_req_ready, lsu_req_ready}), 64'b01);
    cyc(); look();
    check("t2_addr_lsu", 64'(mem_addr), 64'h8000_1000);
    check("t2_lsu_load", 64'(mem_wen), 64'd0);
    repeat (5) cyc();
    clr();
    look();
    check("t2_grant_count", 64'(grants.size()), 64'd3);
    for (int i = 0; i < 3; i++)
      if (grants.size() > i) check("t2_grant_order", 64'(grants[i]), 64'(exp_g[i]));

    // LSU store held in REQ, stray response while stalled, response later
    cyc(); lsu_req_valid = 1; lsu_addr = 32'h8000_2000; lsu_wen = 1;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'b0011; lsu_rsp_ready = 1; look();
    check("t3_accept", 64'(lsu_req_ready), 64'd1);
    cyc(); lsu_req_valid = 0; lsu_addr = '0; lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0;
    mem_rsp_valid = 1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) cyc();
      look();
      check("t3_req_valid", 64'(mem_req_valid), 64'd1);
      check("t3_fields", 64'({mem_wen, mem_wmask, mem_addr}), {27'd0, 1'b1, 4'b0011, 32'h8000_2000});
      check("t3_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
      check("t3_no_rsp", 64'({lsu_rsp_valid, mem_rsp_ready}), 64'd0);
    end
    cyc(); mem_req_ready = 1; look();
    check("t3_same_cycle_rsp_ignored", 64'({lsu_rsp_valid, mem_rsp_ready}), 64'd0);
    cyc(); mem_req_ready = 0; mem_rsp_valid = 0; look();
    check("t3_wait_rsp", 64'(lsu_rsp_valid), 64'd0);
    cyc(); look();
    check("t3_wait_rsp2", 64'(lsu_rsp_valid), 64'd0);
    cyc(); mem_rsp_valid = 1; look();
    check("t3_ack", 64'({lsu_rsp_valid, lsu_rsp_err, mem_rsp_ready}), 64'b101);
    cyc(); mem_rsp_valid = 0; look();
    check("t3_back_idle", 64'(mem_req_valid), 64'd0);

    // LSU load with rsp_ready held low, IFU waiting meanwhile
    cyc(); lsu_req_valid = 1; lsu_addr = 32'h8000_3000; mem_req_ready = 1; lsu_rsp_ready = 0; look();
    check("t4_accept", 64'(lsu_req_ready), 64'd1);
    cyc(); lsu_req_valid = 0; look();
    cyc(); mem_req_ready = 0; mem_rsp_valid = 1; mem_rdata = 32'h55AA_1234;
    ifu_req_valid = 1; ifu_addr = 32'h8000_0010; ifu_rsp_ready = 1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) cyc();
      look();
      check("t4_stall_mem_rsp_ready", 64'(mem_rsp_ready), 64'd0);
      check("t4_no_ifu_accept", 64'(ifu_req_ready), 64'd0);
      check("t4_rsp_pending", 64'(lsu_rsp_valid), 64'd1);
    end
    cyc(); lsu_rsp_ready = 1; look();
    check("t4_handshake", 64'(mem_rsp_ready), 64'd1);
    check("t4_rdata", 64'(lsu_rdata), 64'h55AA_1234);
    cyc(); mem_rsp_valid = 0; look();
    check("t4_idle_next", 64'(ifu_req_ready), 64'd1);
    cyc(); ifu_req_valid = 0; mem_req_ready = 1; look();
    check("t4_ifu_addr", 64'(mem_addr), 64'h8000_0010);
    cyc(); mem_req_ready = 0; mem_rsp_valid = 1; mem_rdata = 32'h0000_0013; look();
    check("t4_ifu_rsp", 64'(ifu_rsp_valid), 64'd1);
    cyc(); clr();

    // Watchdog: memory never answers an IFU fetch
    ifu_req_valid = 1; ifu_addr = 32'h8000_0020; mem_req_ready = 1; ifu_rsp_ready = 0;
    mem_rdata = 32'hFFFF_FFFF; look();
    check("t5_accept", 64'(ifu_req_ready), 64'd1);
    cyc(); ifu_req_valid = 0; look();
    cyc(); mem_req_ready = 0;
    for (int i = 0; i < TO; i++) begin
      if (i > 0) cyc();
      look();
      check("t5_silent", 64'({ifu_rsp_valid, timeout_err}), 64'd0);
    end
    cyc(); look();
    check("t5_err_rsp", 64'({ifu_rsp_valid, ifu_rsp_err, timeout_err, mem_rsp_ready}), 64'b1110);
    check("t5_err_rdata", 64'(ifu_rdata), 64'd0);
    cyc(); mem_rsp_valid = 1; look();
    check("t5_err_hold", 64'({ifu_rsp_valid, ifu_rsp_err, mem_rsp_ready}), 64'b110);
    cyc(); mem_rsp_valid = 0; ifu_rsp_ready = 1; look();
    check("t5_err_handshake", 64'(ifu_rsp_valid), 64'd1);
    cyc(); ifu_rsp_ready = 0; look();
    check("t5_idle_sticky", 64'({mem_req_valid, ifu_rsp_valid, timeout_err}), 64'b001);
    repeat (3) cyc();
    look();
    check("t5_sticky_later", 64'(timeout_err), 64'd1);

    // Reset while in REQ drops the fetch and restores IFU priority
    cyc(); ifu_req_valid = 1; ifu_addr = 32'h8000_0030; mem_req_ready = 0; look();
    check("t6_accept", 64'(ifu_req_ready), 64'd1);
    cyc(); ifu_req_valid = 0; rstn = 0; look();
    check("t6_in_req", 64'(mem_req_valid), 64'd1);
    cyc(); rstn = 1;
    ifu_req_valid = 1; ifu_addr = 32'h8000_0040; lsu_req_valid = 1; lsu_addr = 32'h8000_4000;
    look();
    check("t6_dropped", 64'(mem_req_valid), 64'd0);
    check("t6_sticky_cleared", 64'(timeout_err), 64'd0);
    check("t6_ifu_wins", 64'({ifu_req_ready, lsu_req_ready}), 64'b10);
    cyc(); ifu_req_valid = 0; lsu_req_valid = 0; mem_req_ready = 1; look();
    check("t6_addr", 64'(mem_addr), 64'h8000_0040);
    cyc(); mem_req_ready = 0; mem_rsp_valid = 1; ifu_rsp_ready = 1; look();
    check("t6_rsp", 64'(ifu_rsp_valid), 64'd1);
    cyc(); clr(); look();
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
